// File: rtl/ghostchip_pkg.sv
// ============================================================================
// Module   : ghostchip_pkg
// Brief    : Shared keypad constants, key code type and physical->CHIP-8 map.
//            Macro KEYPAD_REMAP_EN selects the 4x4 hex-pad layout.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ghostchip_pkg;

    localparam int KEY_COUNT = 16;

    typedef logic [3:0] key_code_t;

`ifdef KEYPAD_REMAP_EN
    // Row-major 4x4 pad: 1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F
    localparam key_code_t c_remap_table [KEY_COUNT] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };
`endif

    function automatic key_code_t key_map(input logic [3:0] phys);
`ifdef KEYPAD_REMAP_EN
        return c_remap_table[phys];
`else
        return key_code_t'(phys);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_debounce.sv
// ============================================================================
// Module   : keypad_debounce
// Brief    : Per-key disagreement counter and debounced state, advanced only
//            on its scan-tick enable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_debounce #(
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_tick_en,
    input  logic i_raw,
    output logic o_state,
    output logic o_rise
);

    localparam logic [3:0] c_threshold = 4'(DEBOUNCE_CNT);

    logic [3:0] r_cnt;
    logic       r_state;
    logic [3:0] w_cnt_inc;
    logic       w_flip;

    assign w_cnt_inc = r_cnt + 4'd1;
    assign w_flip    = i_tick_en && (i_raw != r_state) && (w_cnt_inc == c_threshold);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_state <= 1'b0;
        end else if (i_tick_en) begin
            if (i_raw == r_state) begin
                r_cnt <= 4'd0;
            end else if (w_flip) begin
                r_state <= ~r_state;
                r_cnt   <= 4'd0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_state = r_state;
    // Only a 0->1 flip is a press; releases are silent.
    assign o_rise  = w_flip && !r_state;

endmodule

`default_nettype wire

// File: rtl/keypad_scan.sv
// ============================================================================
// Module   : keypad_scan
// Brief    : Time-multiplexed 16-key debouncer with single-slot press event
//            queue. Key remapping selected by macro KEYPAD_REMAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module keypad_scan
    import ghostchip_pkg::*;
#(
    parameter int TICK_DIV     = 256,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  switches_p1,
    input  logic [7:0]  switches_p2,
    output logic [15:0] keypad_matrix,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ack,
    output logic        key_lost
);

    localparam int c_tick_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    logic [15:0]         r_sync1;
    logic [15:0]         r_sync2;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic [3:0]          r_idx;
    logic                r_key_valid;
    key_code_t           r_key_code;
    logic                r_key_lost;

    logic                w_tick;
    logic [15:0]         w_state;
    logic [15:0]         w_rise;
    logic [15:0]         w_matrix;
    logic                w_press;
    logic                w_ack_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 16'd0;
            r_sync2 <= 16'd0;
        end else begin
            r_sync1 <= {switches_p2, switches_p1};
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_tick_cnt == c_tick_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_idx      <= 4'd0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
            r_idx      <= r_idx + 4'd1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < KEY_COUNT; gi++) begin : g_key
            keypad_debounce #(
                .DEBOUNCE_CNT (DEBOUNCE_CNT)
            ) u_debounce (
                .clk       (clk),
                .rst       (reset),
                .i_tick_en (w_tick && (r_idx == 4'(gi))),
                .i_raw     (r_sync2[gi]),
                .o_state   (w_state[gi]),
                .o_rise    (w_rise[gi])
            );
        end
    endgenerate

    // The map is a permutation, so every matrix bit is written exactly once.
    always_comb begin
        w_matrix = 16'd0;
        for (int i = 0; i < KEY_COUNT; i++) begin
            w_matrix[key_map(4'(i))] = w_state[i];
        end
    end

    assign keypad_matrix = w_matrix;

    // Only the key under the scan index can flip, so its code is r_idx's.
    assign w_press  = |w_rise;
    assign w_ack_ok = key_ack && r_key_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_valid <= 1'b0;
            r_key_code  <= 4'd0;
            r_key_lost  <= 1'b0;
        end else if (w_press) begin
            if (!r_key_valid || w_ack_ok) begin
                r_key_valid <= 1'b1;
                r_key_code  <= key_map(r_idx);
                if (w_ack_ok) begin
                    r_key_lost <= 1'b0;
                end
            end else begin
                r_key_lost <= 1'b1;
            end
        end else if (w_ack_ok) begin
            r_key_valid <= 1'b0;
            r_key_lost  <= 1'b0;
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_lost  = r_key_lost;

endmodule

`default_nettype wire

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter TICK_DIV, default 256: clocks per scan step, minimum 2.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 4: consecutive disagreeing samples needed to flip a key state, range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port switches_p1, input, 8 bits: raw physical keys 0..7, asynchronous, active-high.
REQ-006 SHALL have port switches_p2, input, 8 bits: raw physical keys 8..15, asynchronous, active-high.
REQ-007 SHALL have port keypad_matrix, output, 16 bits: debounced key state indexed by CHIP-8 key code; drives cpu keypad_matrix.
REQ-008 SHALL have port key_valid, output, 1 bit: a press event is pending.
REQ-009 SHALL have port key_code, output, 4 bits: CHIP-8 code of the pending press; meaningful only while key_valid=1.
REQ-010 SHALL have port key_ack, input, 1 bit: consumer takes the pending event.
REQ-011 SHALL have port key_lost, output, 1 bit: sticky flag, a press was dropped while an event was pending.

Function
REQ-012 SHALL pass raw = {switches_p2, switches_p1} through a 2-flop synchronizer before any use.
REQ-013 SHALL run tick counter 0..TICK_DIV-1, wrapping; a scan tick occurs on the cycle the counter equals TICK_DIV-1.
REQ-014 SHALL hold scan index idx (0..15), advancing by 1 on each tick and wrapping 15->0; each key is visited every 16*TICK_DIV clocks.
REQ-015 SHALL, on tick, compare synchronized raw[idx] with the debounced state of physical key idx: if equal, clear cnt[idx]; if different, increment cnt[idx].
REQ-016 SHALL, when the increment reaches DEBOUNCE_CNT, toggle that key's state and clear cnt[idx] in the same cycle.
REQ-017 SHALL register keypad_matrix; it updates one cycle after the deciding tick. Latency from a stable raw edge is 2 sync cycles plus at most DEBOUNCE_CNT*16*TICK_DIV clocks.
REQ-018 SHALL, when a key toggles 0->1 and key_valid=0, set key_valid=1 and load key_code with its CHIP-8 code on the next cycle.
REQ-019 SHALL generate no event on a 1->0 toggle.
REQ-020 SHALL, on key_ack=1 with key_valid=1, clear key_valid next cycle; key_ack while key_valid=0 has no effect.
REQ-021 SHALL treat ack and new press in the same cycle as: key_valid stays 1 and key_code takes the new code.
REQ-022 SHALL, on a press with key_valid=1 and no ack, keep the old event (first wins), drop the new one, and set key_lost=1.
REQ-023 SHALL clear key_lost only on an accepted key_ack.

Reset
REQ-024 SHALL, on reset, clear tick counter, idx, all cnt[], the synchronizer, keypad_matrix, key_valid, key_code and key_lost to 0, including reset asserted mid-debounce or mid-event.
REQ-025 SHALL raise no press event for keys already held when reset deasserts until they debounce to 1 normally.

Configuration
REQ-026 SHALL support macro KEYPAD_REMAP_EN. Defined: physical keys 0..15, row-major 4x4, map to CHIP-8 codes 1,2,3,C,4,5,6,D,7,8,9,E,A,0,B,F. Undefined: physical key i maps to code i. The mapping applies to keypad_matrix bit position and key_code.

Structure
REQ-027 SHALL place KEY_COUNT=16, a 4-bit key code typedef and the remap table in shared package ghostchip_pkg.
REQ-028 SHALL implement the per-key counter and state as sub-module keypad_debounce, instantiated 16 times with a per-key tick enable.

Verification
Bench parameters for all scenarios: TICK_DIV=4, DEBOUNCE_CNT=3; per-key visit period is 64 clocks.
REQ-029 SHALL cover: hold switches_p1[0]=1, identity map -> keypad_matrix[0]=1 within 2+192 clocks; key_valid=1, key_code=0.
REQ-030 SHALL cover: switches_p1[5] pulses high for 2 visits then low -> keypad_matrix stays 0, no event.
REQ-031 SHALL cover: press key 3, then key 9 without ack -> key_code=3, key_lost=1; after ack, key_valid=0 and key_lost=0.
REQ-032 SHALL cover: ack coinciding with the debounce of key 7 -> key_valid stays 1, key_code=7.
REQ-033 SHALL cover: KEYPAD_REMAP_EN defined, hold switches_p2[5] (physical 13) -> keypad_matrix[0]=1, key_code=0.
REQ-034 SHALL cover: reset asserted with cnt[2]=2 and key_valid=1 -> all outputs 0 next cycle; key 2 needs 3 fresh visits to set.
